// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the
// transmit-buffer FSM state encoding.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered count/full/empty flags.
// Pushes are ignored when full, pops are ignored when empty.
module uart_sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt_q;
  logic [AW:0]       cnt_d;
  logic              full_q;
  logic              empty_q;
  logic              do_push;
  logic              do_pop;

  // A pop in the same cycle never makes room for a write while full.
  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == FULL_CNT);
      empty_q <= (cnt_d == '0);
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = cnt_q;

endmodule

// File: rtl/uart_tx_buf.sv
// Byte FIFO in front of a uart_tx: pops one byte at a time,
// pulses tx_start and tracks the transmitter busy handshake.
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int BUSY_WAIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   clr_ovf,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [DATA_W-1:0]      tx_data
);

  localparam int TW = $clog2(BUSY_WAIT + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(BUSY_WAIT - 1);

  tx_state_e         state_q;
  tx_state_e         state_d;
  logic [1:0]        rst_sync;
  logic              run;
  logic              pop;
  logic              tmr_clr;
  logic              tmr_inc;
  logic [TW-1:0]     tmr_q;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] data_q;
  logic              ovf_q;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (wr_en),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Reset release reaches the FSM two clocks late.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rst_sync <= 2'b00;
    else
      rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run = rst_sync[1];

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    tmr_clr = 1'b0;
    tmr_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run && !empty && !tx_busy) begin
          state_d = LOAD;
          pop     = 1'b1;
        end
      end
      LOAD: state_d = START;
      START: begin
        state_d = WAIT_BUSY;
        tmr_clr = 1'b1;
      end
      WAIT_BUSY: begin
        if (tx_busy)
          state_d = WAIT_DONE;
        else if (tmr_q == TMR_LAST)
          state_d = IDLE;
        else
          tmr_inc = 1'b1;
      end
      WAIT_DONE: begin
        if (!tx_busy)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (tmr_clr)
        tmr_q <= '0;
      else if (tmr_inc)
        tmr_q <= tmr_q + 1'b1;
      if (pop)
        data_q <= head;
    end
  end

  // An overflowing write beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ovf_q <= 1'b0;
    else if (wr_en && full)
      ovf_q <= 1'b1;
    else if (clr_ovf)
      ovf_q <= 1'b0;
  end

  assign overflow = ovf_q;
  assign tx_start = (state_q == START);
  assign tx_data  = data_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf with a simple uart_tx
// busy model and a tx_start monitor.
module tb_uart_tx_buf;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       clr_ovf;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;

  logic       model_en;
  logic       model_busy;
  logic       man_busy;
  int         busy_cnt;
  int         cyc;
  int         n_chk;
  int         n_pass;
  logic [7:0] got[$];
  int         t_start[$];

  assign tx_busy = model_en ? model_busy : man_busy;

  uart_tx_buf #(
    .DEPTH     (16),
    .BUSY_WAIT (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf),
    .tx_busy  (tx_busy),
    .tx_start (tx_start),
    .tx_data  (tx_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // uart_tx stand-in: busy for 10 cycles after each tx_start
  always @(negedge clk) begin
    if (!reset) begin
      busy_cnt   = 0;
      model_busy = 1'b0;
    end else if (model_en && tx_start) begin
      busy_cnt   = 10;
      model_busy = 1'b1;
    end else if (busy_cnt > 0) begin
      busy_cnt   = busy_cnt - 1;
      model_busy = (busy_cnt != 0);
    end
  end

  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (tx_start === 1'b1) begin
      chk("start_while_busy", 32'(tx_busy), 32'd0);
      got.push_back(tx_data);
      t_start.push_back(cyc);
    end
  end

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    cyc        = 0;
    model_en   = 1'b1;
    man_busy   = 1'b0;
    wr_en      = 1'b0;
    wr_data    = 8'h00;
    clr_ovf    = 1'b0;
    reset      = 1'b1;
    #1 reset   = 1'b0;
    tick(2);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_start", 32'(tx_start), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    reset = 1'b1;
    tick(4);

    // single byte, minimum latency
    wr_data = 8'hA5;
    wr_en   = 1'b1;
    tick(1);
    wr_en = 1'b0;
    chk("lat_count1", 32'(count), 32'd1);
    chk("lat_empty0", 32'(empty), 32'd0);
    tick(1);
    chk("lat_count0", 32'(count), 32'd0);
    chk("lat_nostart", 32'(tx_start), 32'd0);
    tick(1);
    chk("lat_start", 32'(tx_start), 32'd1);
    chk("lat_data", 32'(tx_data), 32'hA5);
    tick(25);
    chk("lat_nstart", 32'(got.size()), 32'd1);
    chk("lat_empty", 32'(empty), 32'd1);

    // fill while busy, overflow and clear
    got.delete();
    t_start.delete();
    model_en = 1'b0;
    man_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        chk("fill_full15", 32'(full), 32'd0);
        chk("fill_cnt15", 32'(count), 32'd15);
      end
      wr_data = 8'(i + 1);
      wr_en   = 1'b1;
      tick(1);
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_cnt", 32'(count), 32'd16);
    chk("fill_ovf0", 32'(overflow), 32'd0);
    wr_data = 8'h11;
    tick(1);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_cnt", 32'(count), 32'd16);
    wr_data = 8'h22;
    clr_ovf = 1'b1;
    tick(1);
    chk("ovf_wins", 32'(overflow), 32'd1);
    wr_en = 1'b0;
    tick(1);
    chk("ovf_clr", 32'(overflow), 32'd0);
    clr_ovf = 1'b0;
    chk("busy_hold", 32'(got.size()), 32'd0);

    // drain through the busy model
    model_en = 1'b1;
    for (int i = 0; i < 2000 && got.size() < 16; i++)
      tick(1);
    tick(20);
    chk("drain_n", 32'(got.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      chk("drain_order", 32'(got[i]), 32'(i + 1));
    chk("drain_empty", 32'(empty), 32'd1);

    // tx_busy never rises: each byte times out
    got.delete();
    t_start.delete();
    model_en = 1'b0;
    man_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_data = 8'(8'h31 + i);
      wr_en   = 1'b1;
      tick(1);
    end
    wr_en = 1'b0;
    tick(30);
    chk("to_n", 32'(got.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk("to_order", 32'(got[i]), 32'(8'h31 + i));
    chk("to_gap1", 32'(t_start[1] - t_start[0]), 32'd7);
    chk("to_gap2", 32'(t_start[2] - t_start[1]), 32'd7);
    chk("to_empty", 32'(empty), 32'd1);

    // reset while in WAIT_DONE with 5 bytes queued
    got.delete();
    t_start.delete();
    for (int i = 0; i < 6; i++) begin
      if (i == 3)
        man_busy = 1'b1;
      wr_data = 8'(8'h41 + i);
      wr_en   = 1'b1;
      tick(1);
    end
    wr_en = 1'b0;
    chk("mid_cnt", 32'(count), 32'd5);
    chk("mid_started", 32'(got.size()), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_empty", 32'(empty), 32'd1);
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_full", 32'(full), 32'd0);
    chk("mid_start", 32'(tx_start), 32'd0);
    chk("mid_data", 32'(tx_data), 32'd0);
    tick(2);
    man_busy = 1'b0;
    reset    = 1'b1;
    got.delete();
    tick(20);
    chk("post_nstart", 32'(got.size()), 32'd0);
    chk("post_empty", 32'(empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_buf.md
UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 Parameter DEPTH, default 16; FIFO entries, power of two, 4..256.
REQ-002 Parameter BUSY_WAIT, default 4; max cycles from tx_start to tx_busy rising.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 wr_en  input  1  write strobe; pushes wr_data when not full.
REQ-006 wr_data  input  8  byte to transmit.
REQ-007 full  output  1  FIFO holds DEPTH bytes.
REQ-008 empty  output  1  FIFO holds 0 bytes.
REQ-009 count  output  log2(DEPTH)+1  current occupancy.
REQ-010 overflow  output  1  sticky; set by a write attempted while full.
REQ-011 clr_ovf  input  1  clears overflow.
REQ-012 tx_busy  input  1  busy flag from the downstream uart_tx transmitter.
REQ-013 tx_start  output  1  one-cycle pulse requesting transmission of tx_data.
REQ-014 tx_data  output  8  byte presented to uart_tx; held stable from tx_start until the FSM returns to IDLE.

Function
REQ-015 FIFO is first-in first-out; a write with wr_en=1 and full=0 stores wr_data at the tail and increments count.
REQ-016 Write while full: data dropped, count unchanged, overflow=1 on the next cycle.
REQ-017 clr_ovf=1 clears overflow next cycle; a simultaneous overflowing write wins (overflow stays 1).
REQ-018 full, empty and count are registered; they reflect all pushes and pops made in the previous cycle.
REQ-019 Simultaneous push and pop when not full: count unchanged. When full, a pop in the same cycle frees no slot for that write; the write is dropped and sets overflow.
REQ-020 Pointers wrap modulo DEPTH; no bubble at the wrap boundary.
REQ-021 FSM states: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE.
REQ-022 IDLE -> LOAD when empty=0 and tx_busy=0; pop head into tx_data register.
REQ-023 LOAD -> START after one cycle; START drives tx_start=1 for exactly that cycle.
REQ-024 START -> WAIT_BUSY; a cycle counter is cleared.
REQ-025 WAIT_BUSY -> WAIT_DONE when tx_busy=1; after BUSY_WAIT cycles with tx_busy=0, -> IDLE and the byte is treated as sent (no retry).
REQ-026 WAIT_DONE -> IDLE when tx_busy=0.
REQ-027 Minimum latency: write in cycle N into an empty FIFO with tx_busy=0 -> tx_start high in cycle N+3.
REQ-028 No pop occurs outside the IDLE->LOAD transition; at most one byte is in flight.
REQ-029 tx_busy=1 while in IDLE blocks a new pop until it falls.

Reset
REQ-030 reset=0 asynchronously forces: FSM=IDLE, pointers=0, count=0, empty=1, full=0, overflow=0, tx_start=0, tx_data=8'h00.
REQ-031 Reset mid-transfer discards FIFO contents and any in-flight byte; no tx_start is issued during reset or in the first cycle after release.
REQ-032 Reset release is synchronised to clk with a 2-flop stage before it reaches the FSM.

Structure
REQ-033 Shared package uart_pkg holds DATA_W=8 and the FSM state encoding; uart_tx and uart_rx reuse DATA_W.
REQ-034 FIFO storage and pointers are in sub-module uart_sync_fifo (DEPTH, DATA_W parameters); uart_tx_buf holds the FSM, overflow flag and busy timer.

Verification
REQ-035 Reset, write 8'hA5 with tx_busy=0 -> tx_start pulse 3 cycles later, tx_data=8'hA5, count returns to 0.
REQ-036 Write 8'h01..8'h10 back-to-back while tx_busy=1 -> full=1 after the 16th write; the 17th write (8'h11) sets overflow. Release tx_busy -> bytes 8'h01..8'h10 leave in order.
REQ-037 The bench models uart_tx with tx_busy held high for 10 cycles per tx_start -> exactly one tx_start per busy period, and no tx_start while tx_busy=1.
REQ-038 tx_busy tied to 0 -> each byte is dropped after BUSY_WAIT=4 cycles, then the FSM returns to IDLE; with 3 bytes queued, 3 tx_start pulses occur.
REQ-039 Assert reset in WAIT_DONE with 5 bytes queued -> all outputs take their reset values immediately, empty=1, and no stale tx_start after release.
REQ-040 Hold clr_ovf=1 in the same cycle as a write while full -> overflow remains 1; clr_ovf alone on the next cycle -> overflow=0.
